// File: rtl/delay_var.sv
// rtl/delay_var.sv - runtime-programmable delay line for data plus valid tag
// Circular buffer read at (wp - delay_cur); delay changes flush the tags and refill.
module delay_var #(
    parameter int WIDTH         = 1,
    parameter int MAX_DELAY     = 16,
    parameter int SEL_WIDTH     = 5,
    parameter int DEFAULT_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [SEL_WIDTH-1:0] delay_sel,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [SEL_WIDTH-1:0] delay_cur,
    output logic                 busy
);

    localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
    localparam logic [SEL_WIDTH-1:0] MAX_SEL = SEL_WIDTH'(MAX_DELAY);
    localparam logic [SEL_WIDTH-1:0] DEF_SEL = SEL_WIDTH'(DEFAULT_DELAY);
    localparam logic [PW-1:0]        WP_LAST = PW'(MAX_DELAY - 1);
    localparam logic [SEL_WIDTH:0]   MAX_EXT = {1'b0, MAX_SEL};

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       data_q  [MAX_DELAY];
    logic [WIDTH-1:0]       data_d  [MAX_DELAY];
    logic [MAX_DELAY-1:0]   valid_q, valid_d;
    logic [PW-1:0]          wp_q, wp_d;
    logic [SEL_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic [SEL_WIDTH-1:0]   delay_cur_q, delay_cur_d;

    logic [SEL_WIDTH-1:0]   dreq;
    logic                   change;
    logic                   fill_done;
    logic [SEL_WIDTH:0]     rd_sum;
    logic [PW-1:0]          rd_idx;

    always_comb begin
        dreq      = (delay_sel > MAX_SEL) ? MAX_SEL : delay_sel;
        change    = enable && (dreq != delay_cur_q);
        fill_done = (delay_cur_q == '0) || (fill_cnt_q == delay_cur_q - SEL_WIDTH'(1));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a delay change outranks fill completion
    always_comb begin
        state_d = state_q;
        if (enable) begin
            if (change) begin
                state_d = FILL;
            end else if (state_q == FILL && fill_done) begin
                state_d = RUN;
            end
        end
    end

    // Datapath next values
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        wp_d        = wp_q;
        fill_cnt_d  = fill_cnt_q;
        delay_cur_d = delay_cur_q;
        if (enable) begin
            if (change) begin
                valid_d     = '0;
                fill_cnt_d  = '0;
                delay_cur_d = dreq;
            end else if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q + SEL_WIDTH'(1);
            end
            data_d[wp_q]  = in;
            valid_d[wp_q] = in_valid && !change;
            wp_d          = (wp_q == WP_LAST) ? '0 : wp_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                data_q[i] <= '0;
            end
            valid_q     <= '0;
            wp_q        <= '0;
            fill_cnt_q  <= '0;
            delay_cur_q <= DEF_SEL;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            wp_q        <= wp_d;
            fill_cnt_q  <= fill_cnt_d;
            delay_cur_q <= delay_cur_d;
        end
    end

    // Read slot (wp - D) mod MAX_DELAY, kept non-negative by adding MAX_DELAY first
    always_comb begin
        rd_sum = {1'b0, SEL_WIDTH'(wp_q)} + MAX_EXT - {1'b0, delay_cur_q};
        if (rd_sum >= MAX_EXT) begin
            rd_sum = rd_sum - MAX_EXT;
        end
        rd_idx = rd_sum[PW-1:0];
    end

    // Output logic
    always_comb begin
        busy      = (state_q == FILL);
        delay_cur = delay_cur_q;
        if (delay_cur_q == '0) begin
            out       = in;
            out_valid = in_valid;
        end else begin
            out       = data_q[rd_idx];
            out_valid = valid_q[rd_idx] && (state_q == RUN);
        end
    end

endmodule

// File: doc/delay_var.md
Name: delay_var

Overview:
- Runtime-programmable delay line for data plus a valid tag, for the tracking channels.
- Replaces fixed-depth instantiated delay chains where the alignment delay is set by software or code-phase logic (e.g. early/prompt/late spacing, correlator pipeline alignment).
- Delay can be 0..MAX_DELAY enabled clocks and can change on the fly.
- A delay change is followed by a controlled flush and refill.

Parameters:
- WIDTH, 1, data width in bits.
- MAX_DELAY, 16, largest supported delay in enabled clocks; must be at least 1.
- SEL_WIDTH, 5, width of the delay select; must satisfy 2^SEL_WIDTH > MAX_DELAY.
- DEFAULT_DELAY, 1, delay in force after reset; must be at most MAX_DELAY.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  clock enable; when 0, no internal state changes.
- delay_sel  input  SEL_WIDTH  requested delay in enabled clocks.
- in_valid  input  1  valid tag accompanying in.
- in  input  WIDTH  data sample.
- out  output  WIDTH  delayed data.
- out_valid  output  1  delayed valid tag; 0 while flushed or refilling.
- delay_cur  output  SEL_WIDTH  delay currently in force.
- busy  output  1  1 while in FILL state.

Behaviour:
- Storage:
  - Circular buffer of MAX_DELAY entries of {valid, data}.
  - Write pointer wp, modulo MAX_DELAY, points to the next slot to write.
  - On each enabled clock: slot wp <= {in_valid, in}; wp <= wp+1, wrapping MAX_DELAY-1 -> 0.
- Output for delay D = delay_cur:
  - D = 0: combinational pass-through, out = in and out_valid = in_valid, regardless of state.
  - D >= 1: out and out_valid are read combinationally from slot (wp - D) mod MAX_DELAY.
  - In steady state, out equals the in value written D enabled clocks earlier, identical to a D-stage register chain.
- Effective request Dreq = min(delay_sel, MAX_DELAY); oversize requests saturate.
- Reset (asynchronous, immediate):
  - All buffer slots cleared to {0,0}; wp = 0.
  - delay_cur = DEFAULT_DELAY; state = FILL; fill_cnt = 0.
  - Outputs: out = 0, out_valid = 0, busy = 1; if DEFAULT_DELAY = 0, out and out_valid follow in and in_valid.
- States:
  - FILL: busy = 1; out_valid forced to 0.
    - Each enabled clock: fill_cnt <= fill_cnt+1.
    - When fill_cnt reaches delay_cur - 1 on an enabled clock, go to RUN on that edge.
    - delay_cur = 0 goes to RUN on the next enabled clock.
  - RUN: busy = 0; out_valid is the stored tag.
- Delay change:
  - On an enabled clock where Dreq != delay_cur, in either state: delay_cur <= Dreq; all stored valid tags cleared; fill_cnt <= 0; state <= FILL.
  - The sample written on that clock is stored with in_valid forced to 0.
  - Data contents are not cleared.
  - A change requested while in FILL restarts the fill.
  - delay_sel is ignored when enable = 0.
- Latency after a change to D >= 1: out_valid is 0 for exactly D enabled clocks after the change edge, then tracks in_valid delayed by D.
- enable = 0:
  - Buffer, wp, state, fill_cnt and delay_cur hold.
  - Outputs stay stable, except in the D = 0 pass-through case.
- Simultaneous events:
  - A delay change takes priority over FILL completion.
  - Reset overrides everything, including mid-fill.
- Wrap-around: pointer arithmetic is modulo MAX_DELAY. D = MAX_DELAY reads the slot about to be overwritten, i.e. the oldest entry.

Test Plan:
1. Reset; DEFAULT_DELAY = 1; delay_sel = 1; enable = 1; in = 1,2,3,... with in_valid = 1 -> busy = 1 for 1 clock; then out = in delayed 1 clock with out_valid = 1; out = 0 and out_valid = 0 during reset.
2. WIDTH = 8, MAX_DELAY = 16; delay_sel = 16; ramp 0..63 -> busy = 1 for 16 clocks; then out = in - 16 mod 256; pointer wraps 4 times with no glitch.
3. In RUN at D = 5, change delay_sel to 3 -> delay_cur = 3 next edge; out_valid = 0 for 3 clocks; busy = 1 for 3 clocks; then out = in delayed 3.
4. delay_sel = 0 -> out = in and out_valid = in_valid in the same cycle; delay_sel = 31 with MAX_DELAY = 16 -> delay_cur = 16.
5. D = 4; toggle enable 1,0,0,1,... -> delay counted in enabled clocks only; outputs hold while enable = 0; a delay_sel change applied while enable = 0 is not taken.
6. Assert reset mid-FILL, and a delay change in the same clock as FILL completion -> reset clears to the post-reset state at once; the delay change wins, staying in FILL with fill_cnt = 0.
